// File: rtl/onewire_bus_arbiter.sv
// Round-robin arbiter sharing one 1-wire transaction engine between N_REQ requesters.
// Optional engine watchdog enabled by defining ONEWIRE_ARB_TIMEOUT_EN.
module onewire_bus_arbiter #(
    parameter int N_REQ          = 3,
    parameter int PTR_W          = 3,
    parameter int TIMEOUT_CYCLES = 6250000
) (
    input  logic               ow_clk,
    input  logic               ow_reset,
    input  logic [N_REQ-1:0]   req_valid,
    input  logic [N_REQ-1:0]   req_lock,
    input  logic [2*N_REQ-1:0] req_op,
    input  logic [8*N_REQ-1:0] req_data,
    output logic [N_REQ-1:0]   req_ready,
    output logic [N_REQ-1:0]   rsp_valid,
    output logic [8:0]         rsp_data,
    output logic               rsp_err,
    output logic [N_REQ-1:0]   grant,
    output logic               eng_cmd_valid,
    output logic [1:0]         eng_cmd_op,
    output logic [7:0]         eng_cmd_data,
    input  logic               eng_cmd_ready,
    input  logic               eng_done,
    input  logic [8:0]         eng_rd_data,
    input  logic               eng_presence,
    output logic               eng_abort
);

    localparam logic [2:0] ARB_IDLE  = 3'd0;
    localparam logic [2:0] ARB_ISSUE = 3'd1;
    localparam logic [2:0] ARB_WAIT  = 3'd2;
    localparam logic [2:0] ARB_RESP  = 3'd3;
    localparam logic [2:0] ARB_HOLD  = 3'd4;

    logic [2:0]       state_q;
    logic [PTR_W-1:0] owner_q;
    logic [PTR_W-1:0] rr_ptr_q;
    logic             lock_q;
    logic [PTR_W-1:0] win_idx;
    logic             win_found;
    logic [PTR_W-1:0] sel_idx;
    logic [PTR_W-1:0] next_rr;
    logic [1:0]       sel_op;
    logic [7:0]       sel_data;
    logic             sel_lock;
    logic             sel_valid;
    logic [N_REQ-1:0] sel_oh;
    logic [N_REQ-1:0] owner_oh;
    logic             accept;
    logic             owner_lock;
    logic             tmo;

    // Round-robin winner: valid requester closest to rr_ptr going upward
    always_comb begin : p_search
        int d;
        int best;
        win_found = 1'b0;
        win_idx   = '0;
        best      = N_REQ;
        for (int k = 0; k < N_REQ; k++) begin
            d = k - int'(rr_ptr_q);
            if (d < 0) d = d + N_REQ;
            if (req_valid[k] && d < best) begin
                best      = d;
                win_idx   = PTR_W'(k);
                win_found = 1'b1;
            end
        end
    end

    assign sel_idx = (state_q == ARB_HOLD) ? owner_q : win_idx;
    assign next_rr = (win_idx == PTR_W'(N_REQ - 1)) ? '0 : win_idx + 1'b1;

    // Pick out the request fields of the candidate and the owner
    always_comb begin
        sel_op     = 2'b00;
        sel_data   = 8'h00;
        sel_lock   = 1'b0;
        sel_valid  = 1'b0;
        sel_oh     = '0;
        owner_oh   = '0;
        owner_lock = 1'b0;
        for (int k = 0; k < N_REQ; k++) begin
            if (PTR_W'(k) == sel_idx) begin
                sel_op    = req_op[2*k +: 2];
                sel_data  = req_data[8*k +: 8];
                sel_lock  = req_lock[k];
                sel_valid = req_valid[k];
                sel_oh[k] = 1'b1;
            end
            if (PTR_W'(k) == owner_q) begin
                owner_oh[k] = 1'b1;
                owner_lock  = req_lock[k];
            end
        end
    end

    assign accept = ((state_q == ARB_IDLE) && win_found) ||
                    ((state_q == ARB_HOLD) && sel_valid);
    assign req_ready     = accept ? sel_oh : '0;
    assign rsp_valid     = (state_q == ARB_RESP) ? owner_oh : '0;
    assign eng_cmd_valid = (state_q == ARB_ISSUE);

`ifdef ONEWIRE_ARB_TIMEOUT_EN
    logic [31:0] wd_q;
    logic        err_q;
    logic        busy;

    assign busy = (state_q == ARB_ISSUE) || (state_q == ARB_WAIT);
    // A done in the limit cycle wins over the timeout
    assign tmo = busy && (wd_q == 32'(TIMEOUT_CYCLES - 1)) &&
                 !((state_q == ARB_WAIT) && eng_done);
    assign rsp_err   = (state_q == ARB_RESP) && err_q;
    assign eng_abort = (state_q == ARB_RESP) && err_q;

    // Watchdog over the issue and wait phases of one operation
    always_ff @(posedge ow_clk) begin
        if (ow_reset) begin
            wd_q  <= '0;
            err_q <= 1'b0;
        end else if (accept) begin
            wd_q  <= '0;
            err_q <= 1'b0;
        end else begin
            if (busy) wd_q <= wd_q + 32'd1;
            if (tmo) err_q <= 1'b1;
        end
    end
`else
    // Without the watchdog the limit has no effect
    assign tmo       = 1'b0;
    assign rsp_err   = 1'b0 & (TIMEOUT_CYCLES == 0);
    assign eng_abort = 1'b0;
`endif

    // Arbitration state, owner, latched command and response capture
    always_ff @(posedge ow_clk) begin
        if (ow_reset) begin
            state_q      <= ARB_IDLE;
            owner_q      <= '0;
            rr_ptr_q     <= '0;
            lock_q       <= 1'b0;
            grant        <= '0;
            eng_cmd_op   <= 2'b00;
            eng_cmd_data <= 8'h00;
            rsp_data     <= 9'h000;
        end else begin
            unique case (state_q)
                ARB_IDLE: begin
                    if (accept) begin
                        eng_cmd_op   <= sel_op;
                        eng_cmd_data <= sel_data;
                        lock_q       <= sel_lock;
                        owner_q      <= win_idx;
                        grant        <= sel_oh;
                        rr_ptr_q     <= next_rr;
                        state_q      <= ARB_ISSUE;
                    end
                end
                ARB_ISSUE: begin
                    if (tmo) begin
                        rsp_data <= 9'h1FF;
                        lock_q   <= 1'b0;
                        state_q  <= ARB_RESP;
                    end else if (eng_cmd_ready) begin
                        state_q <= ARB_WAIT;
                    end
                end
                ARB_WAIT: begin
                    if (eng_done) begin
                        case (eng_cmd_op)
                            2'b00:   rsp_data <= {8'h00, eng_presence};
                            2'b10:   rsp_data <= {1'b0, eng_rd_data[7:0]};
                            2'b11:   rsp_data <= eng_rd_data;
                            default: rsp_data <= 9'h000;
                        endcase
                        state_q <= ARB_RESP;
                    end else if (tmo) begin
                        rsp_data <= 9'h1FF;
                        lock_q   <= 1'b0;
                        state_q  <= ARB_RESP;
                    end
                end
                ARB_RESP: begin
                    if (lock_q) begin
                        state_q <= ARB_HOLD;
                    end else begin
                        grant   <= '0;
                        state_q <= ARB_IDLE;
                    end
                end
                ARB_HOLD: begin
                    if (accept) begin
                        eng_cmd_op   <= sel_op;
                        eng_cmd_data <= sel_data;
                        lock_q       <= sel_lock;
                        state_q      <= ARB_ISSUE;
                    end else if (!owner_lock) begin
                        grant   <= '0;
                        state_q <= ARB_IDLE;
                    end
                end
                default: begin
                    grant   <= '0;
                    state_q <= ARB_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/onewire_bus_arbiter.md
Name: onewire_bus_arbiter

Overview:
- Shares one 1-wire transaction engine (reset / write byte / read byte / read 9-bit) between N requesters, e.g. several temperature-polling sequencers on one DS1821 bus.
- Arbitration is round-robin, one operation at a time.
- A requester can lock the bus across a multi-op sequence (reset, command, read), so no other requester can interleave mid-sequence.
- Sits between the requester FSMs and the bit-level engine on the ow_clk domain.

Parameters:
- N_REQ, 3, number of requesters (2..8).
- PTR_W, 3, width of the owner index; PTR_W >= clog2(N_REQ).
- TIMEOUT_CYCLES, 6250000, engine watchdog limit in ow_clk cycles (1 s at 6.25 MHz). Used only with the optional feature.

Ports:
- ow_clk  in  1  clock
- ow_reset  in  1  synchronous active-high reset
- req_valid  in  N_REQ  per-requester operation request
- req_lock  in  N_REQ  hold the grant after the current op completes
- req_op  in  2*N_REQ  op per requester: 00 reset, 01 write8, 10 read8, 11 read9
- req_data  in  8*N_REQ  write byte per requester
- req_ready  out  N_REQ  request accepted this cycle
- rsp_valid  out  N_REQ  one-cycle completion pulse to the owner
- rsp_data  out  9  read data; {8'h0,presence} for reset; 0 for write
- rsp_err  out  1  qualifies rsp_valid; 1 = engine timeout
- grant  out  N_REQ  one-hot current owner; 0 when the bus is free
- eng_cmd_valid  out  1  command to engine
- eng_cmd_op  out  2  registered op
- eng_cmd_data  out  8  registered write byte
- eng_cmd_ready  in  1  engine accepts command
- eng_done  in  1  one-cycle engine completion pulse
- eng_rd_data  in  9  engine read result (LSB first assembled)
- eng_presence  in  1  presence pulse detected during reset
- eng_abort  out  1  one-cycle abort to engine (timeout only)

Behaviour:
- Reset values:
  - state ARB_IDLE.
  - All outputs 0: req_ready, rsp_valid, rsp_err, grant, eng_cmd_valid, eng_cmd_op, eng_cmd_data, eng_abort, and rsp_data = 9'h0.
  - Round-robin pointer rr_ptr = 0.
- Reset mid-operation: all of the above is forced; the engine is not told. The engine shares ow_reset.
- States: ARB_IDLE, ARB_ISSUE, ARB_WAIT, ARB_RESP, ARB_HOLD.
- ARB_IDLE:
  - Winner is the first asserted req_valid searching from rr_ptr upward, wrapping at N_REQ-1 to 0.
  - req_ready[winner] = 1, combinational from state and req_valid.
  - In the same cycle:
    - latch op, data and lock bit;
    - owner = winner;
    - grant = one-hot(winner) from the next cycle;
    - rr_ptr = winner+1, wrapping to 0 after N_REQ-1;
    - next state ARB_ISSUE.
  - No request: stay in ARB_IDLE.
- ARB_ISSUE:
  - eng_cmd_valid = 1 with the registered op/data.
  - Held until eng_cmd_ready, then ARB_WAIT next cycle.
- ARB_WAIT: on eng_done, capture the result into rsp_data, then ARB_RESP.
  - Read8: rsp_data = {1'b0, eng_rd_data[7:0]}.
  - Read9: rsp_data = eng_rd_data.
  - Reset: rsp_data = {8'h0, eng_presence}.
  - Write: rsp_data = 9'h0.
- ARB_RESP:
  - rsp_valid[owner] = 1 for exactly one cycle; rsp_err = 0.
  - Latched lock = 1: go to ARB_HOLD; grant is kept.
  - Latched lock = 0: go to ARB_IDLE; grant clears next cycle.
- ARB_HOLD:
  - Only the owner is served. req_valid[owner] produces req_ready[owner] = 1, latches op/data/lock, and goes to ARB_ISSUE; rr_ptr is unchanged.
  - req_lock[owner] = 0 with req_valid[owner] = 0: release, grant = 0, go to ARB_IDLE.
  - Other requesters are ignored.
- Latency:
  - Accept to eng_cmd_valid: 1 cycle.
  - eng_done to rsp_valid: 1 cycle.
  - Minimum accept-to-accept for back-to-back ops: 4 cycles + engine time.
- Simultaneous requests: exactly one req_ready per cycle; losers keep req_valid asserted and are served in round-robin order.
- req_valid/req_op/req_data must be held stable until req_ready. Dropping req_valid before req_ready is allowed; nothing is recorded.
- eng_done outside ARB_WAIT is ignored.
- Owner index width is PTR_W bits; a wrap computes to 0, never N_REQ.

Optional Feature:
- Macro: ONEWIRE_ARB_TIMEOUT_EN.
- Defined:
  - A 32-bit watchdog counts cycles in ARB_ISSUE plus ARB_WAIT and clears on every accept.
  - On reaching TIMEOUT_CYCLES, eng_abort pulses 1 cycle and the block goes to ARB_RESP with rsp_err = 1 and rsp_data = 9'h1FF.
  - The lock is force-cleared, so the bus returns to ARB_IDLE.
  - An eng_done arriving in the same cycle as the limit wins: normal response, no error.
- Undefined: no counter; eng_abort and rsp_err are tied 0; the block waits for eng_done indefinitely.

Test Plan:
- Single request, no contention: N_REQ=3, req1 issues write8 data 8'hEE. Required: req_ready[1] in the accept cycle; eng_cmd_op=01 and eng_cmd_data=EE one cycle later; engine sends done; rsp_valid[1] pulses one cycle later with rsp_data=0; grant returns to 0.
- Simultaneous requests: req0, req1 and req2 all valid after reset. Required grant order 0, 1, 2. After owner 2 is served, a new req0 plus req2 gives 0 first.
- Locked sequence: req2 issues reset (lock), then write AA (lock), then read9 (no lock) while req0 is held valid. Required:
  - req0 is not granted until after the read9 response;
  - rsp_data on the reset = 9'h001 when presence = 1;
  - rsp_data on the read9 = the engine's 9'h1A5.
- Release without op: owner in ARB_HOLD drops req_lock with req_valid=0. Required: grant = 0 and state ARB_IDLE the next cycle; a pending req1 is accepted the following cycle.
- Reset mid-operation: ow_reset asserted in ARB_WAIT. Required: next cycle all outputs 0, grant 0, rr_ptr 0, and no rsp_valid ever emitted for the aborted op.
- Timeout (ONEWIRE_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=100): the engine never asserts done. Required: eng_abort after 100 cycles in ARB_ISSUE/ARB_WAIT, then rsp_valid with rsp_err=1 and rsp_data=1FF; the lock is dropped and the bus is free.
